// File: rtl/core_wb_bridge_pkg.sv
// Shared types and constants for the core-to-Wishbone bridge.
package core_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bridge_state_e;

    // Read data returned to the core when a transfer ends in error.
    localparam int unsigned BRIDGE_RDATA_ON_ERR = 0;

    // Index width for an n-entry one-hot vector; never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_wb_bridge_arb.sv
// Round-robin arbiter: one-hot grant plus binary index, rotating
// priority pointer advanced by the caller once a grant is taken.
module rr_arbiter
    import core_wb_bridge_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan from the pointer upward (wrapping) and take the first requester.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand     = (int'(ptr_q) + off) % N;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

    // Next pointer: one past the port just granted, wrapping at N.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/core_wb_bridge.sv
// Bridge from N req/ack core ports to a single Wishbone B4 classic master.
// Optional bus watchdog compiled in with CORE_WB_BRIDGE_TIMEOUT_EN.
module core_wb_bridge
    import core_wb_bridge_pkg::*;
#(
    parameter  int unsigned N_PORTS        = 2,
    parameter  int unsigned ADDR_W         = 32,
    parameter  int unsigned DATA_W         = 32,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned SEL_W          = DATA_W / 8,
    localparam int unsigned IDX_W          = idx_width(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          port_req_i,
    input  logic [N_PORTS-1:0]          port_we_i,
    input  logic [N_PORTS*ADDR_W-1:0]   port_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]   port_wdata_i,
    input  logic [N_PORTS*SEL_W-1:0]    port_sel_i,
    output logic [DATA_W-1:0]           port_rdata_o,
    output logic [N_PORTS-1:0]          port_ack_o,
    output logic [N_PORTS-1:0]          port_err_o,
    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic                        wb_we_o,
    output logic [ADDR_W-1:0]           wb_addr_o,
    output logic [DATA_W-1:0]           wb_data_o,
    output logic [SEL_W-1:0]            wb_sel_o,
    input  logic [DATA_W-1:0]           wb_data_i,
    input  logic                        wb_ack_i,
    input  logic                        wb_err_i
);

    if (N_PORTS < 1 || N_PORTS > 8) begin : g_bad_ports
        $error("core_wb_bridge: N_PORTS must be 1..8");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("core_wb_bridge: DATA_W must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("core_wb_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    bridge_state_e        state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [N_PORTS-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [N_PORTS-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_advance;

`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]      wd_q, wd_d;
`endif

    rr_arbiter #(
        .N (N_PORTS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (port_req_i),
        .advance_i (arb_advance),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx)
    );

    // Next-state logic: grant and latch in IDLE, wait for the slave in BUS,
    // single response cycle in RESP.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        arb_advance = 1'b0;
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|port_req_i) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_grant;
                    addr_d      = port_addr_i[arb_idx*ADDR_W +: ADDR_W];
                    wdata_d     = port_wdata_i[arb_idx*DATA_W +: DATA_W];
                    sel_d       = port_sel_i[arb_idx*SEL_W +: SEL_W];
                    we_d        = port_we_i[arb_idx];
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    state_d     = BUS;
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end
            end
            BUS: begin
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                // err outranks ack; ack outranks the watchdog.
                if (wb_err_i) begin
                    rdata_d = DATA_W'(BRIDGE_RDATA_ON_ERR);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (wb_ack_i) begin
                    rdata_d = we_q ? '0 : wb_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = DATA_W'(BRIDGE_RDATA_ON_ERR);
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            gnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Output decode from registered state only.
    always_comb begin
        wb_cyc_o     = (state_q == BUS);
        wb_stb_o     = (state_q == BUS);
        wb_we_o      = we_q;
        wb_addr_o    = addr_q;
        wb_data_o    = wdata_q;
        wb_sel_o     = sel_q;
        port_rdata_o = rdata_q;
        port_ack_o   = (state_q == RESP) ? gnt_q : '0;
        port_err_o   = (state_q == RESP && err_q) ? gnt_q : '0;
    end

endmodule

// File: tb/tb_core_wb_bridge.sv
// Randomised self-checking bench for core_wb_bridge against a
// transaction-level reference model (round-robin grant, timed bus window).
module tb_core_wb_bridge;

    localparam int unsigned N     = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned TO    = 8;
    localparam int          NEVER = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      port_req = '0;
    logic [N-1:0]      port_we = '0;
    logic [N*AW-1:0]   port_addr = '0;
    logic [N*DW-1:0]   port_wdata = '0;
    logic [N*SW-1:0]   port_sel = '0;
    logic [DW-1:0]     port_rdata;
    logic [N-1:0]      port_ack;
    logic [N-1:0]      port_err;
    logic              wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_dout;
    logic [SW-1:0]     wb_sel;
    logic [DW-1:0]     wb_din = '0;
    logic              wb_ack = 1'b0;
    logic              wb_err = 1'b0;

    core_wb_bridge #(
        .N_PORTS        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_req_i   (port_req),
        .port_we_i    (port_we),
        .port_addr_i  (port_addr),
        .port_wdata_i (port_wdata),
        .port_sel_i   (port_sel),
        .port_rdata_o (port_rdata),
        .port_ack_o   (port_ack),
        .port_err_o   (port_err),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_dout),
        .wb_sel_o     (wb_sel),
        .wb_data_i    (wb_din),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Pending core requests, one slot per port.
    bit            pend[N];
    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_wdata[N];
    logic          r_we[N];
    logic [SW-1:0] r_sel[N];

    // Reference model of the transaction in flight.
    int unsigned   ptr = 0;
    bit            active = 0;
    bit            dropped = 0;
    bit            to_flag = 0;
    int unsigned   g = 0, s = 0, blen = 0, w = 0, next_ready = 0;
    int            err_mode = 0;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata, sdata;
    logic          e_we, e_err;
    logic [SW-1:0] e_sel;

    // Stimulus knobs and one-shot overrides for the next grant.
    int unsigned   gen_pct = 0, hold_pct = 0, drop_pct = 0, spur_pct = 0;
    int unsigned   wmax = 0, err_pct = 0;
    logic [N-1:0]  gen_mask = '0;
    int            f_w = -1, f_err = -1;
    bit            f_data_en = 0;
    logic [DW-1:0] f_data = '0;
    bit            rst_hold = 1, rst_req = 0, post_rst = 1;

    int unsigned   cyc_seen = 0;
    int unsigned   ack_cyc[$];
    int unsigned   ack_port[$];

    function automatic void new_req(input int unsigned i);
        pend[i]    = 1;
        r_addr[i]  = $urandom;
        r_we[i]    = 1'($urandom_range(1));
        r_wdata[i] = $urandom;
        r_sel[i]   = SW'($urandom_range(15, 1));
    endfunction

    function automatic void set_req(input int unsigned i, input logic [AW-1:0] a, input logic we,
                                    input logic [DW-1:0] d, input logic [SW-1:0] sl);
        pend[i] = 1; r_addr[i] = a; r_we[i] = we; r_wdata[i] = d; r_sel[i] = sl;
    endfunction

    task automatic step();
        logic [N-1:0] reqv;
        bit exp_bus, exp_resp, found;
        int unsigned c;
        @(negedge clk);
        n++;
        exp_bus  = active && n >= s && n < s + blen;
        exp_resp = active && n == s + blen;
        check_eq("cyc", 64'(wb_cyc), 64'(exp_bus));
        check_eq("stb", 64'(wb_stb), 64'(exp_bus));
        check_eq("ack", 64'(port_ack), exp_resp ? (64'd1 << g) : 64'd0);
        check_eq("err", 64'(port_err), (exp_resp && e_err) ? (64'd1 << g) : 64'd0);
        if (exp_bus) begin
            check_eq("wb_we", 64'(wb_we), 64'(e_we));
            check_eq("wb_addr", 64'(wb_addr), 64'(e_addr));
            check_eq("wb_data", 64'(wb_dout), 64'(e_wdata));
            check_eq("wb_sel", 64'(wb_sel), 64'(e_sel));
        end
        if (exp_resp) check_eq("rdata", 64'(port_rdata), 64'(e_rdata));
        if (post_rst) begin
            check_eq("rst_addr", 64'(wb_addr), 64'd0);
            check_eq("rst_wdata", 64'(wb_dout), 64'd0);
            check_eq("rst_sel_we", 64'({wb_sel, wb_we}), 64'd0);
            check_eq("rst_rdata", 64'(port_rdata), 64'd0);
            post_rst = 0;
        end
        if (wb_cyc) cyc_seen++;
        for (int unsigned i = 0; i < N; i++) begin
            if (port_ack[i]) begin
                ack_cyc.push_back(n);
                ack_port.push_back(i);
            end
        end

        if (exp_resp) begin
            active  = 0;
            pend[g] = 0;
            if ($urandom_range(99) < hold_pct) new_req(g);
        end
        for (int unsigned i = 0; i < N; i++)
            if (!pend[i] && gen_mask[i] && $urandom_range(99) < gen_pct) new_req(i);
        if (active && !dropped && $urandom_range(99) < drop_pct) dropped = 1;

        for (int unsigned i = 0; i < N; i++) begin
            if (pend[i] && !(active && g == i)) begin
                port_addr[i*AW +: AW]  = r_addr[i];
                port_wdata[i*DW +: DW] = r_wdata[i];
                port_sel[i*SW +: SW]   = r_sel[i];
                port_we[i]             = r_we[i];
            end else begin
                port_addr[i*AW +: AW]  = $urandom;
                port_wdata[i*DW +: DW] = $urandom;
                port_sel[i*SW +: SW]   = SW'($urandom);
                port_we[i]             = 1'($urandom_range(1));
            end
            reqv[i] = pend[i] && !(active && g == i && dropped);
        end
        port_req = reqv;

        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_din = $urandom;
        if (active && !to_flag && n == s + w) begin
            wb_ack = (err_mode != 1);
            wb_err = (err_mode != 0);
            wb_din = sdata;
        end else if (!exp_bus && $urandom_range(99) < spur_pct) begin
            wb_ack = 1'($urandom_range(1));
            wb_err = 1'($urandom_range(1));
        end

        rst = rst_hold || rst_req;
        if (rst) begin
            active = 0; ptr = 0; next_ready = n + 1; post_rst = 1; rst_req = 0;
        end else if (!active && n >= next_ready && reqv != '0) begin
            found = 0;
            for (int unsigned k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (!found && reqv[c]) begin found = 1; g = c; end
            end
            ptr     = (g + 1) % N;
            w       = (f_w >= 0) ? f_w : $urandom_range(wmax);
`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
            to_flag = (w >= TO);
`else
            to_flag = 0;
`endif
            blen     = to_flag ? TO : w + 1;
            err_mode = (f_err >= 0) ? f_err :
                       (($urandom_range(99) < err_pct) ? int'($urandom_range(2, 1)) : 0);
            sdata    = f_data_en ? f_data : $urandom;
            e_addr = r_addr[g]; e_wdata = r_wdata[g]; e_we = r_we[g]; e_sel = r_sel[g];
            e_err    = to_flag || err_mode != 0;
            e_rdata  = (e_err || e_we) ? '0 : sdata;
            s          = n + 1;
            next_ready = s + blen + 1;
            active     = 1;
            dropped    = 0;
            f_w = -1; f_err = -1; f_data_en = 0;
        end
    endtask

    task automatic drain();
        bit busy;
        busy = 1;
        for (int k = 0; k < 400 && busy; k++) begin
            step();
            busy = active;
            for (int unsigned i = 0; i < N; i++) if (pend[i]) busy = 1;
        end
        check_eq("drain_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int unsigned i = 0; i < N; i++) pend[i] = 0;
        repeat (3) step();
        rst_hold = 0;
        step();

        // Single read, two wait states.
        set_req(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
        f_w = 2; f_err = 0; f_data_en = 1; f_data = 32'hCAFE_F00D;
        cyc_seen = 0; ack_port.delete(); ack_cyc.delete();
        drain();
        check_eq("A_cyc_len", 64'(cyc_seen), 64'd3);
        check_eq("A_ack_port", 64'(ack_port.size() == 1 ? ack_port[0] : 99), 64'd0);

        // Ports 0 and 1 continuously, zero-wait slave.
        ack_port.delete(); ack_cyc.delete();
        gen_mask = 3'b011; gen_pct = 100; hold_pct = 100; wmax = 0; err_pct = 0;
        repeat (30) step();
        gen_pct = 0; hold_pct = 0;
        drain();
        check_eq("B_ack_count_ok", 64'(ack_port.size() >= 9), 64'd1);
        for (int i = 1; i < ack_port.size(); i++) begin
            check_eq("B_alternate", 64'(ack_port[i]), (ack_port[i-1] == 0) ? 64'd1 : 64'd0);
            check_eq("B_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
        end

        // Write with err and ack together.
        ack_port.delete();
        set_req(1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'h3);
        f_w = 1; f_err = 2;
        drain();
        check_eq("C_ack_port", 64'(ack_port.size() == 1 ? ack_port[0] : 99), 64'd1);

`ifdef CORE_WB_BRIDGE_TIMEOUT_EN
        // Slave never answers, then ack exactly in the limit cycle, then normal.
        set_req(0, 32'h40, 1'b0, 32'h0, 4'hF);
        f_w = NEVER; cyc_seen = 0;
        drain();
        check_eq("E_timeout_len", 64'(cyc_seen), 64'(TO));
        set_req(0, 32'h44, 1'b0, 32'h0, 4'hF);
        f_w = TO - 1; f_err = 0; cyc_seen = 0;
        drain();
        check_eq("E_ack_at_limit_len", 64'(cyc_seen), 64'(TO));
        set_req(0, 32'h48, 1'b0, 32'h0, 4'hF);
        f_w = 1; f_err = 0;
        drain();
`endif

        // Reset during BUS with the pointer away from port 0.
        wmax = 2;
        set_req(0, 32'h80, 1'b0, 32'h0, 4'hF);
        f_w = 5;
        repeat (3) step();
        set_req(1, 32'h84, 1'b0, 32'h0, 4'hF);
        rst_req = 1;
        step();
        ack_port.delete();
        drain();
        check_eq("F_first_after_rst", 64'(ack_port.size() > 0 ? ack_port[0] : 99), 64'd0);

        // Port 0 re-requests with a new address straight through RESP.
        ack_cyc.delete();
        set_req(0, 32'hA0, 1'b0, 32'h0, 4'hF);
        hold_pct = 100; wmax = 0;
        repeat (8) step();
        hold_pct = 0;
        drain();
        check_eq("G_hold_spacing", 64'(ack_cyc.size() >= 2 ? ack_cyc[1] - ack_cyc[0] : 0), 64'd3);

        // Random mix.
        gen_mask = '1; gen_pct = 30; hold_pct = 40; drop_pct = 20; spur_pct = 15;
        wmax = 3; err_pct = 25;
        repeat (3000) step();
        gen_pct = 0; hold_pct = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
